// File: rtl/dcache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped data cache
// (8 blocks x 4 bytes, 8-bit byte address).
package dcache_pkg;

  localparam int TAG_W           = 3;
  localparam int INDEX_W         = 3;
  localparam int OFFSET_W        = 2;
  localparam int NUM_BLOCKS      = 8;
  localparam int BLOCK_W         = 32;
  localparam int BYTES_PER_BLOCK = BLOCK_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    MEM_READ,
    UPDATE
  } state_e;

endpackage

// File: rtl/dcache_storage.sv
// Data, tag, valid and dirty arrays: combinational read of the indexed block,
// synchronous byte store or whole-block fill.
module dcache_storage
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                srst,
  input  logic [INDEX_W-1:0]  index,
  output logic [BLOCK_W-1:0]  rd_block,
  output logic [TAG_W-1:0]    rd_tag,
  output logic                rd_valid,
  output logic                rd_dirty,
  input  logic                byte_we,
  input  logic [OFFSET_W-1:0] wr_offset,
  input  logic [7:0]          wr_byte,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_block
);

  logic [BLOCK_W-1:0]    data_mem [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_mem  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid_reg;
  logic [NUM_BLOCKS-1:0] dirty_reg;
  logic [BLOCK_W-1:0]    merged_block;

  assign rd_block = data_mem[index];
  assign rd_tag   = tag_mem[index];
  assign rd_valid = valid_reg[index];
  assign rd_dirty = dirty_reg[index];

  // A byte store rewrites the whole word with only the addressed lane replaced.
  for (genvar gi = 0; gi < BYTES_PER_BLOCK; gi++) begin : g_lane
    assign merged_block[8*gi +: 8] =
      (byte_we && wr_offset == OFFSET_W'(gi)) ? wr_byte : rd_block[8*gi +: 8];
  end

  always_ff @(posedge clk) begin
    if (fill_we || byte_we) begin
      data_mem[index] <= fill_we ? fill_block : merged_block;
    end
    if (fill_we) begin
      tag_mem[index] <= fill_tag;
    end
  end

  // Data and tags are left untouched by reset; only the status bits clear.
  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= '0;
      dirty_reg <= '0;
    end else if (fill_we) begin
      valid_reg[index] <= 1'b1;
      dirty_reg[index] <= 1'b0;
    end else if (byte_we) begin
      dirty_reg[index] <= 1'b1;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Write-back, write-allocate direct-mapped data cache controller: hit logic
// and the IDLE / WRITE_BACK / MEM_READ / UPDATE miss-handling FSM.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  state_e state_reg, state_next;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  logic [BLOCK_W-1:0]  rd_block;
  logic [TAG_W-1:0]    rd_tag;
  logic                rd_valid;
  logic                rd_dirty;
  logic                req;
  logic                hit;
  logic                byte_we;
  logic                fill_we;
  logic [BLOCK_W-1:0]  fill_reg;

  assign addr_tag    = ADDRESS[7:5];
  assign addr_index  = ADDRESS[4:2];
  assign addr_offset = ADDRESS[1:0];

  assign req = READ | WRITE;
  assign hit = rd_valid & (rd_tag == addr_tag);

  assign BUSYWAIT = req & ~((state_reg == dcache_pkg::IDLE) & hit) & ~RESET;
  assign READDATA = READ ? rd_block[{addr_offset, 3'b000} +: 8] : 8'h00;

  // A combined READ+WRITE is a store; the load data path is still driven.
  assign byte_we = WRITE & (state_reg == dcache_pkg::IDLE) & hit & ~RESET;

  dcache_storage u_storage (
    .clk        (CLK),
    .srst       (RESET),
    .index      (addr_index),
    .rd_block   (rd_block),
    .rd_tag     (rd_tag),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .byte_we    (byte_we),
    .wr_offset  (addr_offset),
    .wr_byte    (WRITEDATA),
    .fill_we    (fill_we),
    .fill_tag   (addr_tag),
    .fill_block (fill_reg)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= dcache_pkg::IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (state_reg == dcache_pkg::MEM_READ && !MEM_BUSYWAIT) begin
      fill_reg <= MEM_READDATA;
    end
  end

  always_comb begin
    state_next    = state_reg;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0;
    fill_we       = 1'b0;
    case (state_reg)
      dcache_pkg::IDLE: begin
        if (req && !hit) begin
          state_next = (rd_valid && rd_dirty) ? dcache_pkg::WRITE_BACK : dcache_pkg::MEM_READ;
        end
      end
      dcache_pkg::WRITE_BACK: begin
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {rd_tag, addr_index};
        MEM_WRITEDATA = rd_block;
        if (!MEM_BUSYWAIT) begin
          state_next = dcache_pkg::MEM_READ;
        end
      end
      dcache_pkg::MEM_READ: begin
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {addr_tag, addr_index};
        if (!MEM_BUSYWAIT) begin
          state_next = dcache_pkg::UPDATE;
        end
      end
      dcache_pkg::UPDATE: begin
        fill_we    = 1'b1;
        state_next = dcache_pkg::IDLE;
      end
      default: state_next = dcache_pkg::IDLE;
    endcase
    // Reset aborts any transfer in flight; memory must see the request drop at once.
    if (RESET) begin
      MEM_READ  = 1'b0;
      MEM_WRITE = 1'b0;
      fill_we   = 1'b0;
    end
  end

endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high. Clock port is CLK, reset port is RESET.
REQ-002 The block SHALL have no parameters; the cache geometry is fixed: 8 blocks of 4 bytes, direct-mapped, 8-bit byte address.
REQ-003 CLK  input  1  system clock; all state changes on rising edge.
REQ-004 RESET  input  1  synchronous active-high reset.
REQ-005 READ  input  1  CPU load request; held stable while BUSYWAIT=1.
REQ-006 WRITE  input  1  CPU store request; held stable while BUSYWAIT=1.
REQ-007 ADDRESS  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-008 WRITEDATA  input  8  CPU store byte.
REQ-009 READDATA  output  8  CPU load byte.
REQ-010 BUSYWAIT  output  1  CPU stall.
REQ-011 MEM_READ  output  1  memory block-read request.
REQ-012 MEM_WRITE  output  1  memory block-write request.
REQ-013 MEM_ADDRESS  output  6  memory block address {tag,index}.
REQ-014 MEM_WRITEDATA  output  32  block to memory; byte n on bits [8n+7:8n].
REQ-015 MEM_READDATA  input  32  block from memory; same byte order.
REQ-016 MEM_BUSYWAIT  input  1  memory busy; a request completes on the first rising edge at which MEM_BUSYWAIT=0 while the request is asserted.

Function
REQ-017 FSM states SHALL be IDLE, WRITE_BACK, MEM_READ and UPDATE.
REQ-018 Hit SHALL be defined as valid[index] & (tag[index]==ADDRESS[7:5]); it is evaluated combinationally.
REQ-019 BUSYWAIT SHALL equal (READ|WRITE) & ~(state==IDLE & hit), and is 0 when no request is present.
REQ-020 Read hit: READDATA SHALL be the addressed byte in the same cycle, with zero stall cycles.
REQ-021 Write hit: the byte SHALL be written and dirty[index] set at the rising edge of the request cycle, with zero stall cycles.
REQ-022 Simultaneous READ and WRITE SHALL be treated as WRITE.
REQ-023 IDLE with a miss: the FSM SHALL go to WRITE_BACK if valid & dirty, else to MEM_READ; with no miss or no request it stays in IDLE.
REQ-024 WRITE_BACK SHALL drive MEM_WRITE=1, MEM_ADDRESS={stored tag,index} and MEM_WRITEDATA=stored block; on completion it goes to MEM_READ.
REQ-025 MEM_READ SHALL drive MEM_READ=1 and MEM_ADDRESS={ADDRESS[7:5],index}; on completion it goes to UPDATE.
REQ-026 UPDATE SHALL load MEM_READDATA captured at completion into the block, set tag, set valid=1, clear dirty, and return to IDLE after one cycle.
REQ-027 On return to IDLE the request SHALL resolve as a hit under REQ-020/021.
REQ-028 Clean-miss stall SHALL be k+3 cycles, where k is the number of cycles MEM_BUSYWAIT stays high.
REQ-029 Dirty-miss stall SHALL be (kw+1)+(kr+1)+2 cycles.
REQ-030 MEM_READ and MEM_WRITE SHALL never be high together, and SHALL be 0 in IDLE and UPDATE.
REQ-031 READDATA SHALL be 0 when READ=0.
REQ-032 MEM_WRITEDATA SHALL be 0 outside WRITE_BACK.

Reset
REQ-033 RESET=1 at a rising edge SHALL set state to IDLE and clear all valid and dirty bits; data and tag arrays are not cleared.
REQ-034 While RESET=1, the outputs BUSYWAIT, MEM_READ and MEM_WRITE SHALL be 0.
REQ-035 Reset during WRITE_BACK or MEM_READ SHALL abort the transfer; dirty data is discarded by design.

Structure
REQ-036 Package dcache_pkg SHALL hold the state enum, TAG_W=3, INDEX_W=3, OFFSET_W=2, NUM_BLOCKS=8 and BLOCK_W=32.
REQ-037 Sub-module dcache_storage SHALL hold the data, tag, valid and dirty arrays with a combinational read port and a synchronous write port (byte write and block fill); dcache_controller holds the FSM and the hit logic.

Verification
REQ-038 Scenario: after reset, READ ADDRESS=8'h25 with k=4 -> MEM_READ with MEM_ADDRESS=6'h09, BUSYWAIT high for 7 cycles, then READDATA equal to byte 1 of the returned block.
REQ-039 Scenario: after a fill of 8'h25, READ 8'h26 -> BUSYWAIT=0 and the byte returned in the same cycle, with no memory activity.
REQ-040 Scenario: WRITE 8'h25 with data 8'hAB (hit), then READ 8'hA5 -> WRITE_BACK with MEM_ADDRESS=6'h09 and byte 1 = 8'hAB, followed by MEM_READ with MEM_ADDRESS=6'h29; the stall matches REQ-029.
REQ-041 Scenario: READ and WRITE both high on a hit -> store performed and dirty set.
REQ-042 Scenario: RESET asserted in the third cycle of MEM_READ -> next cycle is IDLE with MEM_READ=0, and a subsequent READ of the same address misses.
REQ-043 Scenario: back-to-back hits on 4 consecutive bytes of one block -> zero stall cycles throughout.
